// File: rtl/lc4_pipe_hazard_ctrl.sv
// LC4 five-stage pipeline sequencer: load-use / redirect hazard detection, per-stage
// stall codes carried to W, and saturating W-stage bubble/flush counters.
module lc4_pipe_hazard_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter logic [1:0]  RESET_CODE = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic [2:0]       d_rs,
    input  logic [2:0]       d_rt,
    input  logic             d_rs_re,
    input  logic             d_rt_re,
    input  logic             d_is_store,
    input  logic             d_is_branch,
    input  logic [2:0]       x_rd,
    input  logic             x_is_load,
    input  logic             x_redirect,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic [1:0]       x_code,
    output logic [1:0]       w_code,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        CODE_VALID  = 2'd0,
        CODE_UNUSED = 2'd1,
        CODE_FLUSH  = 2'd2,
        CODE_BUBBLE = 2'd3
    } code_t;

    code_t d_c, x_c, m_c, w_c;
    logic  x_valid;
    logic  lu;
    logic  rd;
    logic  dep;

    always_comb begin
        x_valid = (x_c == CODE_VALID);
        // STR's rt is bypassed W->M, so only non-store rt reads create a dependence
        dep = (d_rs_re && (d_rs == x_rd))
            || (d_rt_re && !d_is_store && (d_rt == x_rd))
            || d_is_branch;
        lu  = x_valid && x_is_load && (d_c == CODE_VALID) && dep;
        rd  = x_valid && x_redirect;
    end

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        if (rd) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (lu) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_bubble = 1'b1;
        end
    end

    assign x_code = x_c;
    assign w_code = w_c;

    // Reset is gated by gwe like every other state update.
    always_ff @(posedge clk) begin
        if (gwe) begin
            if (rst) begin
                d_c        <= code_t'(RESET_CODE);
                x_c        <= code_t'(RESET_CODE);
                m_c        <= code_t'(RESET_CODE);
                w_c        <= code_t'(RESET_CODE);
                bubble_cnt <= '0;
                flush_cnt  <= '0;
            end else begin
                w_c <= m_c;
                m_c <= x_c;
                if (rd) begin
                    x_c <= CODE_FLUSH;
                    d_c <= CODE_FLUSH;
                end else if (lu) begin
                    x_c <= CODE_BUBBLE;
                    d_c <= d_c;
                end else begin
                    x_c <= d_c;
                    d_c <= CODE_VALID;
                end
                if ((w_c == CODE_BUBBLE) && (bubble_cnt != '1)) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
                if ((w_c == CODE_FLUSH) && (flush_cnt != '1)) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lc4_pipe_hazard_ctrl.sv
// Directed bench for lc4_pipe_hazard_ctrl: a default instance plus a narrow-counter
// instance with RESET_CODE=3 to exercise saturation and the reset-code parameter.
module tb_lc4_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, gwe;
    logic [2:0] d_rs, d_rt, x_rd;
    logic       d_rs_re, d_rt_re, d_is_store, d_is_branch, x_is_load, x_redirect;

    logic        a_pc_we, a_fd_we, a_fd_flush, a_dx_bubble;
    logic [1:0]  a_x_code, a_w_code;
    logic [15:0] a_bubble_cnt, a_flush_cnt;

    logic        b_pc_we, b_fd_we, b_fd_flush, b_dx_bubble;
    logic [1:0]  b_x_code, b_w_code;
    logic [1:0]  b_bubble_cnt, b_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lc4_pipe_hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .gwe(gwe),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_re(d_rs_re), .d_rt_re(d_rt_re),
        .d_is_store(d_is_store), .d_is_branch(d_is_branch),
        .x_rd(x_rd), .x_is_load(x_is_load), .x_redirect(x_redirect),
        .pc_we(a_pc_we), .fd_we(a_fd_we), .fd_flush(a_fd_flush), .dx_bubble(a_dx_bubble),
        .x_code(a_x_code), .w_code(a_w_code),
        .bubble_cnt(a_bubble_cnt), .flush_cnt(a_flush_cnt)
    );

    lc4_pipe_hazard_ctrl #(.CNT_W(2), .RESET_CODE(2'b11)) dut_b (
        .clk(clk), .rst(rst), .gwe(gwe),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_re(d_rs_re), .d_rt_re(d_rt_re),
        .d_is_store(d_is_store), .d_is_branch(d_is_branch),
        .x_rd(x_rd), .x_is_load(x_is_load), .x_redirect(x_redirect),
        .pc_we(b_pc_we), .fd_we(b_fd_we), .fd_flush(b_fd_flush), .dx_bubble(b_dx_bubble),
        .x_code(b_x_code), .w_code(b_w_code),
        .bubble_cnt(b_bubble_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; gwe = 1'b1;
        d_rs = '0; d_rt = '0; x_rd = '0;
        d_rs_re = 1'b0; d_rt_re = 1'b0; d_is_store = 1'b0; d_is_branch = 1'b0;
        x_is_load = 1'b0; x_redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1: reset, then gwe gating of reset and of normal advance
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_x_code", a_x_code, 2);
        check_eq("rst_w_code", a_w_code, 2);
        check_eq("rst_bubble", a_bubble_cnt, 0);
        check_eq("rst_flush", a_flush_cnt, 0);
        check_eq("rst_b_x_code", b_x_code, 3);
        check_eq("rst_b_w_code", b_w_code, 3);
        check_eq("rst_b_bubble", b_bubble_cnt, 0);
        tick();
        tick();
        check_eq("drain_flush2", a_flush_cnt, 2);
        check_eq("drain_b_bubble2", b_bubble_cnt, 2);
        check_eq("drain_x_code0", a_x_code, 0);
        rst = 1'b1; gwe = 1'b0;
        tick();
        check_eq("rst_nogwe_x_code", a_x_code, 0);
        check_eq("rst_nogwe_w_code", a_w_code, 2);
        check_eq("rst_nogwe_flush", a_flush_cnt, 2);
        check_eq("rst_nogwe_b_bubble", b_bubble_cnt, 2);
        rst = 1'b0;
        tick();
        check_eq("freeze_flush", a_flush_cnt, 2);
        check_eq("freeze_b_bubble", b_bubble_cnt, 2);
        gwe = 1'b1;
        tick(); tick(); tick();
        check_eq("drain_flush4", a_flush_cnt, 4);
        check_eq("sat_b_bubble", b_bubble_cnt, 3);
        check_eq("sat_b_flush", b_flush_cnt, 0);
        check_eq("drain_w_code0", a_w_code, 0);

        // T2: load-use on rs
        x_is_load = 1'b1; x_rd = 3'd3; d_rs = 3'd3; d_rs_re = 1'b1;
        #1;
        check_eq("lu_pc_we", a_pc_we, 0);
        check_eq("lu_fd_we", a_fd_we, 0);
        check_eq("lu_fd_flush", a_fd_flush, 0);
        check_eq("lu_dx_bubble", a_dx_bubble, 1);
        tick();
        check_eq("lu_x_code3", a_x_code, 3);
        check_eq("lu_reissue_pc_we", a_pc_we, 1);
        check_eq("lu_reissue_dx_bubble", a_dx_bubble, 0);
        idle();
        tick(); tick();
        check_eq("lu_w_code3", a_w_code, 3);
        tick();
        check_eq("lu_bubble1", a_bubble_cnt, 1);
        check_eq("lu_b_bubble_sat", b_bubble_cnt, 3);

        // T3: store rt is bypassed; non-store rt and mismatches
        x_is_load = 1'b1; x_rd = 3'd2; d_rt = 3'd2; d_rt_re = 1'b1;
        d_is_store = 1'b1; d_rs = 3'd5; d_rs_re = 1'b1;
        #1;
        check_eq("str_pc_we", a_pc_we, 1);
        check_eq("str_dx_bubble", a_dx_bubble, 0);
        d_is_store = 1'b0;
        #1;
        check_eq("rt_lu_dx_bubble", a_dx_bubble, 1);
        idle();
        x_is_load = 1'b1; x_rd = 3'd4; d_rs = 3'd3; d_rs_re = 1'b1;
        #1;
        check_eq("rd_mismatch_pc_we", a_pc_we, 1);
        d_rs = 3'd4; d_rs_re = 1'b0;
        #1;
        check_eq("rs_noread_pc_we", a_pc_we, 1);
        tick();
        check_eq("no_lu_x_code0", a_x_code, 0);

        // T4: branch after load
        idle();
        x_is_load = 1'b1; x_rd = 3'd7; d_is_branch = 1'b1;
        #1;
        check_eq("br_dx_bubble", a_dx_bubble, 1);
        check_eq("br_pc_we", a_pc_we, 0);
        tick();
        check_eq("br_x_code3", a_x_code, 3);
        idle();
        tick(); tick(); tick();
        check_eq("br_bubble2", a_bubble_cnt, 2);

        // T5: redirect wins over a simultaneous load-use
        x_redirect = 1'b1; x_is_load = 1'b1; x_rd = 3'd3; d_rs = 3'd3; d_rs_re = 1'b1;
        #1;
        check_eq("rd_pc_we", a_pc_we, 1);
        check_eq("rd_fd_we", a_fd_we, 1);
        check_eq("rd_fd_flush", a_fd_flush, 1);
        check_eq("rd_dx_bubble", a_dx_bubble, 1);
        tick();
        check_eq("rd_x_code2", a_x_code, 2);
        idle();
        x_redirect = 1'b1;
        #1;
        check_eq("rd_ignored_fd_flush", a_fd_flush, 0);
        check_eq("rd_ignored_pc_we", a_pc_we, 1);
        tick();
        check_eq("rd_d_code2", a_x_code, 2);
        idle();
        tick();
        check_eq("rd_w_code2", a_w_code, 2);
        tick(); tick();
        check_eq("rd_flush6", a_flush_cnt, 6);
        check_eq("rd_b_flush2", b_flush_cnt, 2);
        check_eq("rd_bubble_hold", a_bubble_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
